// File: rtl/swap_data_memory_pkg.sv
// Shared definitions for swap_data_memory: request op encoding and FSM states.
// SWAPMEM_CLEAR_EN adds the post-reset CLEAR sweep state.
package swap_mem_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CSWAP = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    WR0,
    WR1,
`ifdef SWAPMEM_CLEAR_EN
    CLEAR,
`endif
    RESP
  } state_t;

endpackage

// File: rtl/swap_data_memory_if.sv
// Request/response bus of swap_data_memory; master = sort controller, slave = memory.
interface swap_data_memory_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              ReqValid;
  logic              ReqReady;
  logic [1:0]        ReqOp;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic              RspValid;
  logic [DATA_W-1:0] ReadData;
  logic              Swapped;
  logic              Error;

  modport master (
    output ReqValid, ReqOp, Address, WriteData,
    input  ReqReady, RspValid, ReadData, Swapped, Error
  );

  modport slave (
    input  ReqValid, ReqOp, Address, WriteData,
    output ReqReady, RspValid, ReadData, Swapped, Error
  );
endinterface

// File: rtl/swap_mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
module swap_mem_array #(
  parameter int    DATA_W    = 8,
  parameter int    DEPTH     = 32,
  parameter int    ADDR_W    = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic              Clk,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_rdEn,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdData;

  always_ff @(posedge Clk) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
    if (i_rdEn) r_rdData <= r_mem[i_rdAddr];
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/swap_data_memory.sv
// Single-port data memory with READ, WRITE and atomic compare-and-swap of A/A+1.
// Define SWAPMEM_CLEAR_EN to zero every entry in a CLEAR sweep after reset.
module swap_data_memory
  import swap_mem_pkg::*;
#(
  parameter int    DATA_W     = 8,
  parameter int    DEPTH      = 32,
  parameter int    ADDR_W     = $clog2(DEPTH),
  parameter bit    SIGNED_CMP = 1'b0,
  parameter string INIT_FILE  = ""
) (
  input  logic               Clk,
  input  logic               Rst_n,
  swap_data_memory_if.slave  bus
);

  localparam logic [ADDR_W:0]   DEPTH_EXT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic              r_swapped;
  logic [DATA_W-1:0] r_rA;
  logic [DATA_W-1:0] r_rB;
  logic [DATA_W-1:0] r_readData;
`ifdef SWAPMEM_CLEAR_EN
  logic [ADDR_W-1:0] r_clrIdx;
`endif

  logic              w_accept;
  logic              w_reqErr;
  logic              w_gt;
  logic [ADDR_W-1:0] w_addrPlus1;
  logic              w_wrEn;
  logic [ADDR_W-1:0] w_wrAddr;
  logic [DATA_W-1:0] w_wrData;
  logic              w_rdEn;
  logic [ADDR_W-1:0] w_rdAddr;
  logic [DATA_W-1:0] w_rdData;

  swap_mem_array #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .Clk      (Clk),
    .i_wrEn   (w_wrEn),
    .i_wrAddr (w_wrAddr),
    .i_wrData (w_wrData),
    .i_rdEn   (w_rdEn),
    .i_rdAddr (w_rdAddr),
    .o_rdData (w_rdData)
  );

  assign bus.ReqReady = (r_state == IDLE) && Rst_n;
  assign w_accept     = bus.ReqValid && bus.ReqReady;
  assign w_addrPlus1  = r_addr + ADDR_W'(1);

  // No wrap-around: a CSWAP at the last entry has no partner and is rejected.
  assign w_reqErr = (bus.ReqOp == OP_RSVD) ||
                    ({1'b0, bus.Address} >= DEPTH_EXT) ||
                    ((bus.ReqOp == OP_CSWAP) && (bus.Address == LAST_ADDR));

  // In RD1 the array output holds mem[A+1]; equal values never swap.
  assign w_gt = SIGNED_CMP ? ($signed(r_rA) > $signed(w_rdData)) : (r_rA > w_rdData);

  assign bus.RspValid = (r_state == RESP);
  assign bus.Swapped  = (r_state == RESP) && r_swapped;
  assign bus.Error    = (r_state == RESP) && r_err;
  assign bus.ReadData = ((r_state == RESP) && (r_op == OP_READ) && !r_err) ? w_rdData : r_readData;

  always_comb begin
    w_nextState = r_state;
    w_wrEn      = 1'b0;
    w_wrAddr    = r_addr;
    w_wrData    = r_rB;
    w_rdEn      = 1'b0;
    w_rdAddr    = bus.Address;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_reqErr) begin
            w_nextState = RESP;
          end else begin
            case (bus.ReqOp)
              OP_READ: begin
                w_rdEn      = 1'b1;
                w_nextState = RESP;
              end
              OP_WRITE: begin
                w_wrEn      = 1'b1;
                w_wrAddr    = bus.Address;
                w_wrData    = bus.WriteData;
                w_nextState = RESP;
              end
              default: begin
                w_rdEn      = 1'b1;
                w_nextState = RD0;
              end
            endcase
          end
        end
      end
      RD0: begin
        w_rdEn      = 1'b1;
        w_rdAddr    = w_addrPlus1;
        w_nextState = RD1;
      end
      RD1: w_nextState = w_gt ? WR0 : RESP;
      WR0: begin
        w_wrEn      = 1'b1;
        w_nextState = WR1;
      end
      WR1: begin
        w_wrEn      = 1'b1;
        w_wrAddr    = w_addrPlus1;
        w_wrData    = r_rA;
        w_nextState = RESP;
      end
      RESP: w_nextState = IDLE;
`ifdef SWAPMEM_CLEAR_EN
      CLEAR: begin
        w_wrEn   = 1'b1;
        w_wrAddr = r_clrIdx;
        w_wrData = '0;
        if (r_clrIdx == LAST_ADDR) w_nextState = IDLE;
      end
`endif
      default: w_nextState = IDLE;
    endcase
    // A reset edge aborts any write in flight; there is no rollback of earlier ones.
    if (!Rst_n) w_wrEn = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
`ifdef SWAPMEM_CLEAR_EN
      r_state  <= CLEAR;
      r_clrIdx <= '0;
`else
      r_state  <= IDLE;
`endif
      r_op       <= OP_READ;
      r_addr     <= '0;
      r_err      <= 1'b0;
      r_swapped  <= 1'b0;
      r_rA       <= '0;
      r_rB       <= '0;
      r_readData <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op      <= bus.ReqOp;
            r_addr    <= bus.Address;
            r_err     <= w_reqErr;
            r_swapped <= 1'b0;
          end
        end
        RD0: r_rA <= w_rdData;
        RD1: begin
          r_rB      <= w_rdData;
          r_swapped <= w_gt;
        end
        RESP: begin
          if ((r_op == OP_READ) && !r_err) r_readData <= w_rdData;
        end
`ifdef SWAPMEM_CLEAR_EN
        CLEAR: r_clrIdx <= r_clrIdx + ADDR_W'(1);
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_swap_data_memory.sv
// Scoreboard bench for swap_data_memory: unsigned DEPTH=32 and signed DEPTH=20 instances.
// Build with SWAPMEM_CLEAR_EN to check the post-reset clear sweep.
module tb_swap_data_memory;
  import swap_mem_pkg::*;

`ifdef SWAPMEM_CLEAR_EN
  localparam int CLR_A = 32;
  localparam int CLR_B = 20;
`else
  localparam int CLR_A = 0;
  localparam int CLR_B = 0;
`endif

  typedef struct {
    int         cyc;
    bit         swp;
    bit         err;
    logic [7:0] rd;
  } exp_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  swap_data_memory_if #(.DATA_W(8), .ADDR_W(5)) busA ();
  swap_data_memory_if #(.DATA_W(8), .ADDR_W(5)) busB ();

  swap_data_memory #(.DATA_W(8), .DEPTH(32), .SIGNED_CMP(1'b0), .INIT_FILE("")) dutA (
    .Clk(clk), .Rst_n(rstN), .bus(busA.slave));
  swap_data_memory #(.DATA_W(8), .DEPTH(20), .SIGNED_CMP(1'b1), .INIT_FILE("")) dutB (
    .Clk(clk), .Rst_n(rstN), .bus(busB.slave));

  exp_t       qA[$];
  exp_t       qB[$];
  logic [7:0] model [2][32];
  logic [7:0] lastRd [2];
  int         cyc = 0;
  int         nChecks = 0;
  int         nFails = 0;
  bit         monOn = 1'b0;
  exp_t       eA, eB;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic rdy(input int which);
    return (which == 0) ? busA.ReqReady : busB.ReqReady;
  endfunction

  // Reference model: memory semantics straight from the op rules.
  task automatic predict(input int which, input logic [1:0] op, input logic [4:0] addr,
                         input logic [7:0] data, input int acc);
    int         depth;
    exp_t       e;
    logic [7:0] a, b;
    bit         gt;
    depth = (which == 0) ? 32 : 20;
    e.err = (op == 2'b11) || (int'(addr) >= depth) || (op == 2'b10 && int'(addr) == depth - 1);
    e.swp = 1'b0;
    e.cyc = acc;
    if (!e.err) begin
      case (op)
        2'b00: lastRd[which] = model[which][addr];
        2'b01: model[which][addr] = data;
        default: begin
          a  = model[which][addr];
          b  = model[which][addr + 1];
          gt = (which == 1) ? ($signed(a) > $signed(b)) : (a > b);
          if (gt) begin
            model[which][addr]     = b;
            model[which][addr + 1] = a;
            e.swp = 1'b1;
            e.cyc = acc + 4;
          end else begin
            e.cyc = acc + 2;
          end
        end
      endcase
    end
    e.rd = lastRd[which];
    if (which == 0) qA.push_back(e);
    else            qB.push_back(e);
  endtask

  task automatic applyStimulus(input int which, input logic [1:0] op, input logic [4:0] addr,
                               input logic [7:0] data, input bit track, output int acc);
    int waited = 0;
    bit ok;
    acc = -1;
    do begin
      @(negedge clk);
      ok = rdy(which);
      waited++;
    end while (!ok && waited < 100);
    if (!ok) begin
      checkOutput("ReqReady timeout", {31'd0, ok}, 32'd1);
      return;
    end
    if (which == 0) begin
      busA.ReqValid = 1'b1; busA.ReqOp = op; busA.Address = addr; busA.WriteData = data;
    end else begin
      busB.ReqValid = 1'b1; busB.ReqOp = op; busB.Address = addr; busB.WriteData = data;
    end
    @(posedge clk);
    #1;
    busA.ReqValid = 1'b0;
    busB.ReqValid = 1'b0;
    acc = cyc;
    if (track) predict(which, op, addr, data, acc);
  endtask

  task automatic req(input int which, input logic [1:0] op, input logic [4:0] addr, input logic [7:0] data);
    int acc;
    applyStimulus(which, op, addr, data, 1'b1, acc);
  endtask

  task automatic readyDelay(input int which, input int expv);
    int n = 0;
    @(negedge clk);
    while (!rdy(which) && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput((which == 0) ? "A ready after reset" : "B ready after reset", n, expv);
  endtask

  task automatic modelReset();
    lastRd[0] = 8'h00;
    lastRd[1] = 8'h00;
`ifdef SWAPMEM_CLEAR_EN
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 32; i++) model[w][i] = 8'h00;
`endif
  endtask

  // Scoreboard monitor: every response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (monOn) begin
      if (busA.RspValid) begin
        if (qA.size() == 0) checkOutput("A unexpected RspValid", {31'd0, busA.RspValid}, 32'd0);
        else begin
          eA = qA.pop_front();
          checkOutput("A latency", cyc, eA.cyc);
          checkOutput("A Swapped", {31'd0, busA.Swapped}, {31'd0, eA.swp});
          checkOutput("A Error", {31'd0, busA.Error}, {31'd0, eA.err});
          checkOutput("A ReadData", {24'd0, busA.ReadData}, {24'd0, eA.rd});
          checkOutput("A ReqReady in RESP", {31'd0, busA.ReqReady}, 32'd0);
        end
      end else begin
        checkOutput("A flags without RspValid", {30'd0, busA.Swapped, busA.Error}, 32'd0);
      end
      if (busB.RspValid) begin
        if (qB.size() == 0) checkOutput("B unexpected RspValid", {31'd0, busB.RspValid}, 32'd0);
        else begin
          eB = qB.pop_front();
          checkOutput("B latency", cyc, eB.cyc);
          checkOutput("B Swapped", {31'd0, busB.Swapped}, {31'd0, eB.swp});
          checkOutput("B Error", {31'd0, busB.Error}, {31'd0, eB.err});
          checkOutput("B ReadData", {24'd0, busB.ReadData}, {24'd0, eB.rd});
          checkOutput("B ReqReady in RESP", {31'd0, busB.ReqReady}, 32'd0);
        end
      end else begin
        checkOutput("B flags without RspValid", {30'd0, busB.Swapped, busB.Error}, 32'd0);
      end
    end
  end

  initial begin
    int c1, c2, n;
    busA.ReqValid = 1'b0; busA.ReqOp = OP_READ; busA.Address = '0; busA.WriteData = '0;
    busB.ReqValid = 1'b0; busB.ReqOp = OP_READ; busB.Address = '0; busB.WriteData = '0;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("A ReqReady in reset", {31'd0, busA.ReqReady}, 32'd0);
    checkOutput("B ReqReady in reset", {31'd0, busB.ReqReady}, 32'd0);
    checkOutput("A outputs in reset", {21'd0, busA.RspValid, busA.Swapped, busA.Error, busA.ReadData}, 32'd0);
    checkOutput("B outputs in reset", {21'd0, busB.RspValid, busB.Swapped, busB.Error, busB.ReadData}, 32'd0);
    rstN = 1'b1;
    modelReset();
    fork
      readyDelay(0, CLR_A);
      readyDelay(1, CLR_B);
    join
    monOn = 1'b1;

`ifdef SWAPMEM_CLEAR_EN
    for (int i = 0; i < 32; i++) req(0, OP_READ, 5'(i), 8'h00);
    for (int i = 0; i < 20; i++) req(1, OP_READ, 5'(i), 8'h00);
`else
    for (int i = 0; i < 32; i++) req(0, OP_WRITE, 5'(i), 8'($urandom));
    for (int i = 0; i < 20; i++) req(1, OP_WRITE, 5'(i), 8'($urandom));
`endif

    // Directed cases: swap, no swap, equal values, edge errors, signedness.
    req(0, OP_WRITE, 5'd0, 8'h08); req(0, OP_WRITE, 5'd1, 8'h05);
    req(0, OP_CSWAP, 5'd0, 8'h00);
    req(0, OP_READ, 5'd0, 8'h00);  req(0, OP_READ, 5'd1, 8'h00);
    req(0, OP_WRITE, 5'd2, 8'h02); req(0, OP_WRITE, 5'd3, 8'h40);
    req(0, OP_CSWAP, 5'd2, 8'h00);
    req(0, OP_READ, 5'd2, 8'h00);  req(0, OP_READ, 5'd3, 8'h00);
    req(0, OP_WRITE, 5'd4, 8'h05); req(0, OP_WRITE, 5'd5, 8'h05);
    req(0, OP_CSWAP, 5'd4, 8'h00);
    req(0, OP_READ, 5'd4, 8'h00);
    req(0, OP_CSWAP, 5'd31, 8'h00);
    req(0, OP_READ, 5'd30, 8'h00); req(0, OP_READ, 5'd31, 8'h00);
    req(0, OP_WRITE, 5'd6, 8'hFF); req(0, OP_WRITE, 5'd7, 8'h01);
    req(0, OP_CSWAP, 5'd6, 8'h00);
    req(0, OP_READ, 5'd6, 8'h00);
    req(1, OP_WRITE, 5'd0, 8'hFF); req(1, OP_WRITE, 5'd1, 8'h01);
    req(1, OP_CSWAP, 5'd0, 8'h00);
    req(1, OP_READ, 5'd0, 8'h00);
    req(1, OP_READ, 5'd25, 8'h00);
    req(1, OP_CSWAP, 5'd19, 8'h00);
    req(1, OP_RSVD, 5'd2, 8'h00);

    applyStimulus(0, OP_WRITE, 5'd3, 8'hAA, 1'b1, c1);
    applyStimulus(0, OP_READ, 5'd3, 8'h00, 1'b1, c2);
    checkOutput("back-to-back accept spacing", c2 - c1, 32'd2);

    for (int i = 0; i < 200; i++)
      req(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 8'($urandom));

    // Reset landing in WR1 of a swapping CSWAP: first write stays, second is lost.
    req(0, OP_WRITE, 5'd10, 8'h90); req(0, OP_WRITE, 5'd11, 8'h10);
    applyStimulus(0, OP_CSWAP, 5'd10, 8'h00, 1'b0, c1);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b0;
    @(posedge clk);
    #1 rstN = 1'b1;
    model[0][10] = 8'h10;
    modelReset();
    fork
      readyDelay(0, CLR_A);
      readyDelay(1, CLR_B);
    join
    req(0, OP_READ, 5'd10, 8'h00);
    req(0, OP_READ, 5'd11, 8'h00);
`ifdef SWAPMEM_CLEAR_EN
    for (int i = 0; i < 32; i++) req(0, OP_READ, 5'(i), 8'h00);
`endif

    n = 0;
    while ((qA.size() != 0 || qB.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("A responses outstanding", qA.size(), 32'd0);
    checkOutput("B responses outstanding", qB.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
